arbitro_dados: RTL
==================

// Module: arbitro_dados
// PURPOSE
//  Two-port arbiter/sequencer in front of the single-port data memory (dados).
//  Requester 0 is the CPU load/store stage; requester 1 is the I/O/DMA port.
//  Latches one request at a time, drives label/dadoEscrito/LerMemo/EscrMemo,
//  waits the read latency, returns read data and pulses ack to the winner.
// PARAMETERS
//  LARGURA      8  data and address width (bits)
//  LAT_LEITURA  1  cycles LerMemo is held before escrever is sampled (1..15)
// PORTS
//  clk              in   1        system clock, rising edge
//  reset            in   1        asynchronous, active-low reset
//  req0, req1       in   1        access request, level; held until ack
//  wr0, wr1         in   1        1 = write, 0 = read (sampled with req)
//  addr0, addr1     in   LARGURA  memory address
//  wdata0, wdata1   in   LARGURA  write data
//  ack0, ack1       out  1        one-cycle completion pulse
//  rdata0, rdata1   out  LARGURA  read data, valid while ackN=1, held after
//  mem_label        out  LARGURA  address to dados
//  mem_dadoEscrito  out  LARGURA  write data to dados
//  mem_LerMemo      out  1        read strobe to dados
//  mem_EscrMemo     out  1        write strobe to dados
//  mem_escrever     in   LARGURA  read data from dados
//  ocupado          out  1        1 whenever state != OCIOSO
// BEHAVIOUR
//  - Reset (reset=0, async): state=OCIOSO, all outputs 0, cnt=0, ultimo=1
//    (so req0 wins the first tie). Mid-access reset drops strobes immediately;
//    the interrupted access is never acked.
//  - FSM: OCIOSO -> ACESSO -> RESPOSTA -> OCIOSO.
//  - OCIOSO: if any req, pick winner, latch wr/addr/wdata, go ACESSO next edge.
//    No req: stay, strobes 0.
//  - Round-robin: single req -> that one; both -> the one != ultimo;
//    ultimo updated at grant.
//  - ACESSO write: mem_EscrMemo=1 for exactly 1 cycle, label/dadoEscrito =
//    latched values; then RESPOSTA.
//  - ACESSO read: mem_LerMemo=1 for LAT_LEITURA cycles (cnt counts 0..LAT-1);
//    on last cycle's edge capture mem_escrever into rdataN; then RESPOSTA.
//  - Strobes mutually exclusive; never both 1. mem_label stable for whole ACESSO.
//  - RESPOSTA: ackN=1 for one cycle (winner only), strobes 0; -> OCIOSO.
//  - Latency req-sampled -> ack: write 2 cycles, read LAT_LEITURA+1 cycles.
//    Back-to-back throughput: one access per 3 (write) / LAT+2 (read) cycles.
//  - req/addr/wdata changes after grant are ignored (latched copy used).
//  - Requester holding req after ack is re-arbitrated in OCIOSO as a new
//    access; under contention the other requester is served first.
//  - Loser's req stays pending; no starvation: max wait = one other access.
//  - rdataN of the non-winner is unchanged; write access leaves rdataN unchanged.
// CONFIGURATION
//  ARB_PRIO_FIXA_EN defined: fixed priority, req0 always wins ties; ultimo
//    unused (req1 may starve under continuous req0).
//  Not defined: round-robin as above (default build).
// TESTING
//  1 Reset: reset=0 mid-read -> strobes, acks, ocupado = 0 same cycle; no ack
//    after release.
//  2 req0 write addr=7 wdata=5 -> EscrMemo=1 one cycle with label=7,
//    dadoEscrito=5; ack0 2 cycles after sampling.
//  3 req1 read addr=7 (LAT=1, dados holds 5) -> LerMemo 1 cycle, label=7;
//    ack1 with rdata1=5; rdata0 unchanged.
//  4 req0 & req1 both high same cycle from reset -> order 0,1,0,1 while both
//    held; with ARB_PRIO_FIXA_EN -> 0,0,0.
//  5 LAT_LEITURA=3 read addr=0x10 -> LerMemo high 3 cycles; ack 4 cycles after
//    sampling; addr0 changed to 0x20 during ACESSO -> label stays 0x10.
//  6 Check every cycle: !(mem_LerMemo & mem_EscrMemo); ack0 & ack1 never both 1.

Source files
------------

// File: rtl/arbitro_dados.sv
// arbitro_dados: two-port arbiter/sequencer in front of the single-port
// data memory (dados). Port 0 = CPU load/store, port 1 = I/O/DMA.
// Ports: clk, reset (async, active-low); reqN/wrN/addrN/wdataN requests;
// ackN/rdataN completion; mem_* drive dados, mem_escrever is its read
// data; ocupado = access in flight.
// Option: ARB_PRIO_FIXA_EN -> fixed priority (req0 wins ties), else
// round-robin.
module arbitro_dados #(
  parameter int LARGURA     = 8,
  parameter int LAT_LEITURA = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0,
  input  logic               req1,
  input  logic               wr0,
  input  logic               wr1,
  input  logic [LARGURA-1:0] addr0,
  input  logic [LARGURA-1:0] addr1,
  input  logic [LARGURA-1:0] wdata0,
  input  logic [LARGURA-1:0] wdata1,
  output logic               ack0,
  output logic               ack1,
  output logic [LARGURA-1:0] rdata0,
  output logic [LARGURA-1:0] rdata1,
  output logic [LARGURA-1:0] mem_label,
  output logic [LARGURA-1:0] mem_dadoEscrito,
  output logic               mem_LerMemo,
  output logic               mem_EscrMemo,
  input  logic [LARGURA-1:0] mem_escrever,
  output logic               ocupado
);

  typedef enum logic [1:0] {
    OCIOSO,
    ACESSO,
    RESPOSTA
  } estado_t;

  localparam logic [3:0] CNT_FIM = 4'(LAT_LEITURA - 1);

  estado_t            estado;
  logic [3:0]         cnt;
  logic               venc;
  logic               ganha;
  logic               wr_sel;
  logic [LARGURA-1:0] addr_sel;
  logic [LARGURA-1:0] wdata_sel;

`ifdef ARB_PRIO_FIXA_EN
  // req0 wins whenever present
  assign ganha = !req0;
`else
  logic ultimo;
  // on contention serve the port that was not served last
  assign ganha = (req0 && req1) ? !ultimo : !req0;
`endif

  assign wr_sel    = ganha ? wr1    : wr0;
  assign addr_sel  = ganha ? addr1  : addr0;
  assign wdata_sel = ganha ? wdata1 : wdata0;
  assign ocupado   = (estado != OCIOSO);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado          <= OCIOSO;
      cnt             <= '0;
      venc            <= 1'b0;
`ifndef ARB_PRIO_FIXA_EN
      ultimo          <= 1'b1;
`endif
      ack0            <= 1'b0;
      ack1            <= 1'b0;
      rdata0          <= '0;
      rdata1          <= '0;
      mem_label       <= '0;
      mem_dadoEscrito <= '0;
      mem_LerMemo     <= 1'b0;
      mem_EscrMemo    <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      unique case (estado)
        OCIOSO: begin
          if (req0 || req1) begin
            venc            <= ganha;
`ifndef ARB_PRIO_FIXA_EN
            ultimo          <= ganha;
`endif
            mem_label       <= addr_sel;
            mem_dadoEscrito <= wdata_sel;
            mem_EscrMemo    <= wr_sel;
            mem_LerMemo     <= !wr_sel;
            cnt             <= '0;
            estado          <= ACESSO;
          end
        end
        ACESSO: begin
          if (mem_EscrMemo) begin
            mem_EscrMemo <= 1'b0;
            ack0         <= !venc;
            ack1         <= venc;
            estado       <= RESPOSTA;
          end else if (cnt == CNT_FIM) begin
            mem_LerMemo <= 1'b0;
            if (venc) rdata1 <= mem_escrever;
            else      rdata0 <= mem_escrever;
            ack0        <= !venc;
            ack1        <= venc;
            estado      <= RESPOSTA;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESPOSTA: begin
          estado <= OCIOSO;
        end
        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule
